// File: rtl/ltssm_timer_bank_if.sv
// ltssm_timer_bank_if: per-channel control strobes, limits and status of the LTSSM timer bank
interface ltssm_timer_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       start_i;
  logic [NUM_CH-1:0]       stop_i;
  logic [NUM_CH-1:0]       periodic_i;
  logic [NUM_CH*CNT_W-1:0] limit_i;
  logic [NUM_CH-1:0]       ack_i;
  logic [NUM_CH-1:0]       active_o;
  logic [NUM_CH-1:0]       expire_o;
  logic [NUM_CH-1:0]       expired_o;
  modport master (
    output start_i, stop_i, periodic_i, limit_i, ack_i,
    input  active_o, expire_o, expired_o
  );
  modport slave (
    input  start_i, stop_i, periodic_i, limit_i, ack_i,
    output active_o, expire_o, expired_o
  );
endinterface

// File: rtl/ltssm_timer_bank.sv
// ltssm_timer_bank: independent one-shot/periodic timeout channels with expiry pulse and sticky flag
module ltssm_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  ltssm_timer_bank_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lim;
    logic             r_per;
    logic             r_exp;
    logic             r_expd;
    logic [CNT_W-1:0] w_lim;
    logic             w_hit;
    assign w_lim = bus.limit_i[c*CNT_W +: CNT_W];
    // start and stop both pre-empt the expiry that would otherwise happen on this edge
    assign w_hit = !bus.start_i[c] && !bus.stop_i[c] && r_state == RUN && r_cnt == r_lim - CNT_W'(1);
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_exp   <= 1'b0;
        r_expd  <= 1'b0;
      end else begin
        r_exp  <= w_hit;
        r_expd <= w_hit | (r_expd & ~bus.ack_i[c]);
        if (bus.start_i[c]) begin
          r_state <= RUN;
          r_cnt   <= '0;
          r_lim   <= (w_lim == '0) ? CNT_W'(1) : w_lim;
          r_per   <= bus.periodic_i[c];
        end else if (bus.stop_i[c]) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (r_state == RUN) begin
          r_cnt <= w_hit ? '0 : r_cnt + CNT_W'(1);
          if (w_hit && !r_per) r_state <= DONE;
        end
      end
    end
    assign bus.active_o[c]  = (r_state == RUN);
    assign bus.expire_o[c]  = r_exp;
    assign bus.expired_o[c] = r_expd;
  end
endmodule

// File: tb/tb_ltssm_timer_bank.sv
// tb_ltssm_timer_bank: directed checks of the timer bank with hand-computed expectations
module tb_ltssm_timer_bank;
  localparam int NC = 4;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  ltssm_timer_bank_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();
  ltssm_timer_bank #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_lim(input int c, input logic [CW-1:0] v);
    bus.limit_i[c*CW +: CW] = v;
  endtask
  initial begin
    int         mism;
    logic       seen;
    logic [3:0] ev;
    bus.start_i = '0; bus.stop_i = '0; bus.periodic_i = '0; bus.ack_i = '0; bus.limit_i = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_active", 32'(bus.active_o), 0);
    chk("rst_expire", 32'(bus.expire_o), 0);
    chk("rst_expired", 32'(bus.expired_o), 0);
    // one-shot L=5 on ch0
    set_lim(0, 5); bus.start_i = 4'b0001;
    tick(1); bus.start_i = '0;
    chk("os_active_e0", 32'(bus.active_o), 32'h1);
    tick(4);
    chk("os_noexp_e4", 32'(bus.expire_o), 0);
    chk("os_active_e4", 32'(bus.active_o), 32'h1);
    tick(1);
    chk("os_expire_e5", 32'(bus.expire_o), 32'h1);
    chk("os_expired_e5", 32'(bus.expired_o), 32'h1);
    chk("os_active_e5", 32'(bus.active_o), 0);
    tick(1);
    chk("os_pulse_once", 32'(bus.expire_o), 0);
    tick(3);
    chk("os_sticky", 32'(bus.expired_o), 32'h1);
    bus.ack_i = 4'b0001; tick(1); bus.ack_i = '0;
    chk("os_ack", 32'(bus.expired_o), 0);
    // periodic L=3 on ch1, stopped at edge 10
    set_lim(1, 3); bus.periodic_i = 4'b0010; bus.start_i = 4'b0010;
    tick(1); bus.start_i = '0; bus.periodic_i = '0;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      chk($sformatf("per_e%0d", e), 32'(bus.expire_o), (e % 3 == 0) ? 32'h2 : 32'h0);
    end
    bus.stop_i = 4'b0010; tick(1); bus.stop_i = '0;
    chk("per_stop_active", 32'(bus.active_o), 0);
    seen = 1'b0;
    for (int e = 11; e <= 13; e++) begin tick(1); seen |= bus.expire_o[1]; end
    chk("per_no_e12", 32'(seen), 0);
    chk("per_sticky_after_stop", 32'(bus.expired_o), 32'h2);
    bus.ack_i = 4'b0010; tick(1); bus.ack_i = '0;
    // restart ch2: L=8 then L=4 at edge 6
    set_lim(2, 8); bus.start_i = 4'b0100;
    tick(1); bus.start_i = '0;
    tick(5);
    set_lim(2, 4); bus.start_i = 4'b0100;
    tick(1); bus.start_i = '0;
    mism = 0;
    for (int e = 7; e <= 12; e++) begin
      tick(1);
      if (bus.expire_o !== ((e == 10) ? 4'b0100 : 4'b0000)) mism++;
    end
    chk("restart_pulse_edges", 32'(mism), 0);
    chk("restart_expired", 32'(bus.expired_o), 32'h4);
    bus.ack_i = 4'b0100; tick(1); bus.ack_i = '0;
    // limit 0 on ch3 behaves as 1
    set_lim(3, 0); bus.start_i = 4'b1000;
    tick(1); bus.start_i = '0;
    chk("lim0_e0", 32'(bus.expire_o), 0);
    tick(1);
    chk("lim0_e1", 32'(bus.expire_o), 32'h8);
    bus.ack_i = 4'b1000; tick(1); bus.ack_i = '0;
    chk("lim0_ack", 32'(bus.expired_o), 0);
    // ack on the expiry edge loses to the set
    set_lim(3, 2); bus.start_i = 4'b1000;
    tick(1); bus.start_i = '0;
    tick(1);
    bus.ack_i = 4'b1000; tick(1); bus.ack_i = '0;
    chk("ack_same_edge_expire", 32'(bus.expire_o), 32'h8);
    chk("ack_same_edge_expired", 32'(bus.expired_o), 32'h8);
    bus.ack_i = 4'b1000; tick(1); bus.ack_i = '0;
    // start and stop together: start wins
    set_lim(3, 5); bus.start_i = 4'b1000; bus.stop_i = 4'b1000;
    tick(1); bus.start_i = '0; bus.stop_i = '0;
    chk("start_stop_active", 32'(bus.active_o), 32'h8);
    bus.stop_i = 4'b1000; tick(1); bus.stop_i = '0;
    chk("stop_idle", 32'(bus.active_o), 0);
    // reset mid-run
    set_lim(0, 100); bus.start_i = 4'b0001;
    tick(1); bus.start_i = '0;
    tick(49);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("midrst_active", 32'(bus.active_o), 0);
    chk("midrst_expire", 32'(bus.expire_o), 0);
    chk("midrst_expired", 32'(bus.expired_o), 0);
    seen = 1'b0;
    for (int e = 51; e <= 150; e++) begin tick(1); seen |= |bus.expire_o; end
    chk("midrst_no_expiry", 32'(seen), 0);
    // all channels concurrently: L=2 per, 7 one-shot, 2400 per, 1000 one-shot
    set_lim(0, 2); set_lim(1, 7); set_lim(2, 2400); set_lim(3, 1000);
    bus.periodic_i = 4'b0101; bus.start_i = 4'b1111;
    tick(1); bus.start_i = '0; bus.periodic_i = '0;
    chk("conc_active_e0", 32'(bus.active_o), 32'hf);
    mism = 0;
    for (int e = 1; e <= 4800; e++) begin
      tick(1);
      ev = {e == 1000, e % 2400 == 0, e == 7, e % 2 == 0};
      if (bus.expire_o !== ev) mism++;
    end
    chk("conc_pulse_edges", 32'(mism), 0);
    chk("conc_active_end", 32'(bus.active_o), 32'h5);
    chk("conc_expired_end", 32'(bus.expired_o), 32'hf);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
